// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (request-to-send, 11-bit frame, ack check)
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tx_data, tx_valid     command byte and request; accepted when tx_valid & tx_ready
//   tx_ready              high only while idle
//   ps2_clk_in            sampled PS/2 clock line (synchronised internally, 3 flops)
//   ps2_data_in           sampled PS/2 data line (synchronised internally, 2 flops)
//   ps2_clk_oe            1 pulls ps2_clk low, 0 releases it
//   ps2_data_oe           1 pulls ps2_data low, 0 releases it
//   tx_done               one-cycle pulse: device acknowledged the byte
//   tx_err                one-cycle pulse: device nacked or the transfer timed out
//   busy                  high whenever a transfer is in progress
//
// Build option: define PS2_TX_RETRY_EN to retry a byte once after its first
// nack or timeout before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);
    localparam int CW = $clog2(INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;

    state_t        state, state_n, fail_state;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic          drive, fall, tmo_hit, timed;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign timed    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign tmo_hit  = tmo == TW'(TIMEOUT_CYCLES - 1);
    assign tx_ready = state == IDLE;
    assign busy     = state != IDLE;

`ifdef PS2_TX_RETRY_EN
    logic retry;
    assign fail_state = retry ? ERR : INHIBIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry <= 1'b0;
        else if (state == DONE || state == ERR)
            retry <= 1'b0;
        else if (timed && state_n == INHIBIT)
            retry <= 1'b1;
    end
`else
    assign fail_state = ERR;
`endif

    always_comb begin
        state_n     = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        case (state)
            IDLE:      if (tx_valid) state_n = INHIBIT;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) state_n = REQ;
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (cnt == CW'(SETUP_CYCLES - 1)) state_n = SEND;
            end
            SEND: begin
                ps2_data_oe = drive;
                state_n = tmo_hit ? fail_state : (fall && bit_cnt == 4'd9) ? ACK : SEND;
            end
            ACK:       state_n = (tmo_hit || (fall && data_sync[1])) ? fail_state : fall ? WAIT_IDLE : ACK;
            WAIT_IDLE: state_n = tmo_hit ? fail_state : (clk_sync[2] && data_sync[1]) ? DONE : WAIT_IDLE;
            DONE: begin
                tx_done = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                tx_err  = 1'b1;
                state_n = IDLE;
            end
            default:   state_n = IDLE;
        endcase
    end

    // Sync flops reset high so an idle bus never looks like a falling edge.
    // drive is preset to 1 in REQ so the start bit stays on the line until the
    // device's first falling edge; bit 9 of shreg is the stop bit (1), so the
    // tenth edge releases data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
            shreg     <= '0;
            bit_cnt   <= '0;
            cnt       <= '0;
            tmo       <= '0;
            drive     <= 1'b0;
        end else begin
            state     <= state_n;
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            if (tx_valid && state == IDLE)
                shreg <= {1'b1, ~^tx_data, tx_data};
            cnt       <= (state_n == state && (state == INHIBIT || state == REQ)) ? cnt + 1'b1 : '0;
            tmo       <= timed ? tmo + 1'b1 : '0;
            bit_cnt   <= (state == SEND) ? bit_cnt + {3'b000, fall} : '0;
            drive     <= (state == REQ) ? 1'b1 : (state == SEND && fall) ? ~shreg[bit_cnt] : drive;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;
    localparam int INH  = 200;
    localparam int SET  = 20;
    localparam int TMO  = 3000;
    localparam int HALF = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int FAIL_PHASES = 2;
`else
    localparam int FAIL_PHASES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err, busy;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .tx_done(tx_done), .tx_err(tx_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_err;
        bit       chk_frame;
        bit [9:0] frame;
        int       lat;
        int       phases;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         total = 0, bad = 0;
    int         phases = 0, acc_cnt = 0, dev_falls = 0, dev_mode = 0;
    int         inh_len = 0, req_len = 0;
    longint     cyc = 0, rel_cyc = 0;
    bit         pend_ready = 0, dev_abort = 0;
    logic       prev_clk_oe = 1'b0, prev_busy = 1'b0;
    logic [9:0] dev_frame = '0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line-level view of a frame: data LSB first, odd parity, stop released high.
    function automatic bit [9:0] ref_frame(input bit [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2) == 0, d};
    endfunction

    // Phase timing, accept counting and the scoreboard monitor.
    always @(negedge clk) begin
        cyc++;
        if (pend_ready) begin
            check("ready_after", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
            pend_ready = 0;
        end
        if (!rst_n) begin
            inh_len = 0;
            req_len = 0;
        end else begin
            if (ps2_clk_oe && !ps2_data_oe) inh_len++;
            else if (inh_len != 0) begin
                check("inhibit_len", inh_len, INH);
                phases++;
                inh_len = 0;
            end
            if (ps2_clk_oe && ps2_data_oe) req_len++;
            else if (req_len != 0) begin
                check("setup_len", req_len, SET);
                check("start_held", ps2_data_oe, 1);
                req_len = 0;
            end
            if (prev_clk_oe && !ps2_clk_oe && busy) rel_cyc = cyc;
            if (!prev_busy && busy) acc_cnt++;
            if (tx_done || tx_err) begin
                check("done_err_excl", tx_done & tx_err, 0);
                check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
                if (sb.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("result_kind", tx_err, e.is_err);
                    if (e.chk_frame) check("frame", dev_frame, e.frame);
                    if (e.lat > 0) check("timeout_lat", cyc - rel_cyc, e.lat);
                    check("inhibit_phases", phases, e.phases);
                end
                phases = 0;
                pend_ready = 1;
            end
        end
        prev_clk_oe = ps2_clk_oe;
        prev_busy   = busy;
    end

    // Device: answers a request-to-send with 11 clock pulses, sampling each bit on the rise.
    task automatic run_frame();
        dev_frame = '0;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 11 && !dev_abort; k++) begin
            if (k == 11 && dev_mode == 0) dev_data = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            dev_falls++;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) dev_frame[k-1] = ps2_data_in;
            repeat (HALF) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (dev_abort) begin
                dev_clk   = 1'b1;
                dev_data  = 1'b1;
                dev_abort = 0;
            end else if (rst_n && ps2_clk_in && !ps2_data_in && dev_mode != 2)
                run_frame();
        end
    end

    // mode: 0 device acks, 1 device nacks, 2 device never clocks
    task automatic send(input logic [7:0] d, input int mode);
        exp_t x;
        @(negedge clk);
        check("ready_before", tx_ready, 1);
        dev_mode    = mode;
        x.is_err    = mode != 0;
        x.chk_frame = mode != 2;
        x.frame     = ref_frame(d);
        x.lat       = (mode == 2) ? TMO : 0;
        x.phases    = (mode == 0) ? 1 : FAIL_PHASES;
        sb.push_back(x);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        check("accept_lat", {busy, ps2_clk_oe}, 2'b11);
        tx_valid = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_bound", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, acc0;
        exp_t x;
        #12;
        check("reset_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 6'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 6'b100000);

        send(8'hED, 0); wait_empty(3000);
        send(8'h00, 0); wait_empty(3000);
        send(8'h01, 1); wait_empty(3000);
        send(8'hFF, 2); wait_empty(10000);

        dev_falls = 0;
        send(8'hF4, 0);
        n = 0;
        while (dev_falls < 4 && n < 3000) begin @(negedge clk); n++; end
        n = 0;
        while (!ps2_data_oe && n < 30) begin @(negedge clk); n++; end
        check("oe_before_reset", ps2_data_oe, 1);
        #2 rst_n = 1'b0;
        dev_abort = 1;
        #1 check("reset_mid", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b0001);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        phases = 0;
        n = 0;
        while (dev_abort && n < 100) begin @(negedge clk); n++; end
        check("device_abort", dev_abort, 0);
        send(8'hF4, 0); wait_empty(3000);

        dev_mode    = 0;
        acc0        = acc_cnt;
        x.is_err    = 0;
        x.chk_frame = 1;
        x.frame     = ref_frame(8'hED);
        x.lat       = 0;
        x.phases    = 1;
        sb.push_back(x);
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_done && n < 3000) begin @(negedge clk); n++; end
        tx_valid = 1'b0;
        check("held_done_seen", tx_done, 1);
        repeat (5) @(negedge clk);
        check("held_accepts", acc_cnt - acc0, 1);
        check("held_idle", busy, 0);
        wait_empty(10);

        for (int i = 0; i < 8; i++) begin
            send(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
            wait_empty(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside the PS/2 scan receiver on the same open-drain ps2_clk/ps2_data pair. Top level builds the tri-state buffers from the *_oe outputs.
- Performs the full request-to-send sequence, shifts data on device-generated clock edges, and checks the device acknowledge bit.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request (100 us at 50 MHz).
- SETUP_CYCLES, 50, clk cycles data is held low with clock still low before clock release.
- TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to ack sample (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  sampled PS/2 clock line
- ps2_data_in  in  1  sampled PS/2 data line
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release
- tx_done  out  1  one-cycle pulse: byte acknowledged
- tx_err  out  1  one-cycle pulse: nack or timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=1, state=IDLE, all counters 0.
- Reset is asynchronous. Asserting rst_n mid-transfer releases both lines immediately and returns to IDLE.
- Input sync: ps2_clk_in passes through 3 flops r0→r1→r2. fall = r2 & ~r1. ps2_data_in passes through 2 flops.
- Latch: on the accept cycle, latch shreg = {1'b1 stop, ~^tx_data odd parity, tx_data}. Bit index 0 = LSB. Ignore tx_valid while busy.
- IDLE → INHIBIT on accept.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles → REQ.
- REQ: clk_oe=1, data_oe=1 (start bit 0) for SETUP_CYCLES cycles → SEND. Clear the bit counter and timeout counter.
- SEND: clk_oe=0. On each fall, count n=1..10:
  - n=1..8: data_oe = ~data bit (n-1)
  - n=9: data_oe = ~parity
  - n=10: data_oe=0 (stop, line released)
  - → ACK after n=10.
- ACK: on the next fall, sample synced data. 0 → WAIT_IDLE. 1 → nack, ERR.
- WAIT_IDLE: wait until synced clock=1 and data=1 → DONE.
- DONE: tx_done=1 for one cycle → IDLE.
- ERR: tx_err=1 for one cycle, both oe=0 → IDLE.
- Timeout: counter runs from REQ exit through SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES → ERR in any of those states.
- tx_done and tx_err never assert in the same cycle.
- Back-to-back: a new byte may be accepted the cycle after DONE/ERR (tx_ready=1 in IDLE).
- Falling edges seen in IDLE, INHIBIT or REQ are ignored and never counted.
- Latency from accept to first clk_oe=1: 1 cycle.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on the first nack or timeout of a byte, skip ERR and re-enter INHIBIT with the same latched shreg. Only a second failure produces tx_err. A retry flag clears on DONE/ERR/reset.
- Not defined: the first failure goes straight to ERR.

Test Plan:
- Send 0xED; device model clocks 11 edges, acks low → data_oe pattern, LSB first, data bits 1,0,1,1,0,1,1,1 driven as oe 0,1,0,0,1,0,0,0; parity bit 1 (oe 0); stop oe 0; single tx_done pulse; busy low after.
- Accept 0x00 → clk_oe high for exactly 5000 cycles, then data_oe high for 50 cycles with clk_oe still high; parity driven 1 (oe 0).
- Send 0x01, device leaves data high in ack slot → tx_err pulse, no tx_done, both oe=0, tx_ready=1 next cycle.
- Send 0xFF, device never clocks → tx_err exactly 1000000 cycles after clock release. With PS2_TX_RETRY_EN: second INHIBIT phase observed, then tx_err.
- Reset asserted after the 4th falling edge of 0xF4 → oe outputs 0 immediately. After release, next accepted byte 0xF4 completes with tx_done.
- tx_valid held high through the transfer of 0xED → exactly one byte sent. A second byte is accepted only when tx_ready=1.
